q_proj_drain: RTL
=================

// Module: q_proj_drain
// PURPOSE
//  Read-side drain for the Q-projection output SRAM (128 x 128b). After the projection engine finishes,
//  this block reads a contiguous run of words from the SRAM read port in address order.
//  It streams them out on a valid/ready interface toward the next stage (attention score / host readback).
//  It hides the 1-cycle SRAM read latency behind a 2-entry skid FIFO, so full-rate streaming has no bubbles.
// PARAMETERS
//  DATA_W   128  SRAM word / stream width
//  ADDR_W   7    SRAM address width (depth 2**ADDR_W)
//  FIFO_D   2    skid FIFO entries (fixed 2; credit logic sized for 1-cycle SRAM latency)
// PORTS
//  clk        in   1         clock; all state on rising edge
//  rst        in   1         asynchronous, active-low reset
//  start      in   1         1-cycle pulse: begin drain; sampled only in IDLE
//  base_addr  in   ADDR_W    first SRAM address, captured on start
//  num_words  in   ADDR_W+1  word count 0..128, captured on start
//  busy       out  1         high from the cycle after start until done
//  done       out  1         1-cycle pulse when the final word handshakes (or for an empty run)
//  MEM_CEB    out  1         SRAM chip enable, active-low; low only on cycles issuing a read
//  MEM_WEN    out  1         SRAM write enable, active-low; tied 1 (read-only master)
//  MEM_ADDR   out  ADDR_W    SRAM read address
//  MEM_DOUT   in   DATA_W    SRAM Q; valid the cycle after CEB=0 (1-cycle latency)
//  m_data     out  DATA_W    stream data
//  m_valid    out  1         stream valid
//  m_ready    in   1         stream ready; a transfer occurs when m_valid & m_ready
//  m_last     out  1         high with the final word of the run
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE; FIFO empty; counters 0.
//   Outputs on reset: busy=0, done=0, MEM_CEB=1, MEM_WEN=1, MEM_ADDR=0, m_valid=0, m_last=0, m_data=0.
//  FSM:
//   IDLE: on start, capture base_addr/num_words.
//    num_words==0 -> DONE. Otherwise -> RUN.
//   RUN: issue reads and move words through the FIFO.
//    Go to DONE on the cycle the final word handshakes.
//   DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
//   start outside IDLE is ignored (no queueing, no restart).
//  Read issue (RUN only):
//   issue = (rd_cnt < num_words) && (fifo_cnt + inflight - pop < 2).
//    inflight = 1 if a read was issued last cycle; pop = m_valid & m_ready this cycle.
//   On issue: MEM_CEB=0, MEM_ADDR = base_addr + rd_cnt (mod 2**ADDR_W, wraps 127->0), rd_cnt++.
//   The word returns on MEM_DOUT the next cycle and is pushed into the FIFO that cycle, unconditionally.
//   The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
//  Stream side:
//   m_valid = FIFO non-empty; m_data = FIFO head, registered and stable while m_valid & !m_ready.
//   m_last = m_valid && (out_cnt == num_words-1).
//   Push and pop in the same cycle: occupancy unchanged and order preserved.
//  Latency: first m_valid 2 cycles after start (issue at T+1, data in FIFO / m_valid at T+2).
//   With m_ready held high: one word per cycle, N words end at T+N+1, done at T+N+2.
//  Backpressure: a stall of any length loses and duplicates no data.
//   Reads stop once 2 words are buffered or in flight.
//  Async reset mid-run aborts immediately: FIFO flushed, outputs to reset values, no done.
//   The SRAM read in flight is discarded.
// TESTING
//  1. Reset values: assert rst=0 mid-stream -> same cycle busy=0, m_valid=0, MEM_CEB=1; no done.
//     Release rst and start again -> clean run.
//  2. Full rate: start, base=0, num=128, m_ready=1.
//     -> 128 words equal SRAM[0..127] in order, 1 per cycle from T+2; m_last on word 127; done at T+130.
//  3. Backpressure: num=8, m_ready toggles 1-in-3, plus one 20-cycle stall.
//     -> data exact and in order, never more than 2 reads outstanding + buffered, m_data stable while stalled.
//  4. Wrap: base=120, num=16 -> MEM_ADDR sequence 120..127,0..7; stream matches; m_last on the 16th word.
//  5. Edge counts:
//     num=0 -> done at T+1, no CEB=0 cycles, no m_valid.
//     num=1 -> one word with m_last=1, done after it handshakes.
//  6. start while busy -> ignored: captured base/num unchanged, no extra reads, single done.

Source files
------------

// File: rtl/q_proj_drain_if.sv
// ---------------------------------------------------------------------------
// q_proj_drain_if
// Valid/ready stream carrying Q-projection words out of the drain.
//   m_data   word being offered
//   m_valid  m_data holds a word
//   m_ready  consumer accepts the word this cycle
//   m_last   the offered word is the final word of the run
// Modports: master = drain side, slave = consumer side.
// ---------------------------------------------------------------------------
interface q_proj_drain_if #(
    parameter int DATA_W = 128
) ();
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/q_proj_drain.sv
// ---------------------------------------------------------------------------
// q_proj_drain
// Reads a contiguous (wrapping) run of words from the Q-projection SRAM and
// streams them out in address order. The 1-cycle SRAM latency is hidden by a
// 2-entry skid FIFO whose input stage is the SRAM return itself, so a word
// coming back on MEM_DOUT is presented immediately and is only registered
// when it cannot leave in the same cycle.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   start                  pulse, accepted only while idle
//   base_addr, num_words   run description, captured on an accepted start
//   busy, done             run in progress / 1-cycle completion pulse
//   MEM_CEB, MEM_WEN       SRAM controls (active-low), write never enabled
//   MEM_ADDR, MEM_DOUT     SRAM read address / read data
//   m                      output stream (q_proj_drain_if master)
// ---------------------------------------------------------------------------
module q_proj_drain #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              MEM_CEB,
    output logic              MEM_WEN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DOUT,
    q_proj_drain_if.master    m
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W:0] ONE = 1;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     num_q;
    logic [ADDR_W:0]     rd_cnt;
    logic [ADDR_W:0]     out_cnt;
    logic                rd_pend;
    logic [1:0]          fifo_cnt;
    logic [DATA_W-1:0]   slot0, slot1;

    logic                valid_w, pop, issue, last_w;
    logic [2:0]          occ_next;

    // Handshake, credit check and SRAM/stream outputs. A returning read
    // (rd_pend) counts as occupancy, so at most two words are ever either
    // in flight or buffered.
    always_comb begin
        valid_w  = (fifo_cnt != 2'd0) || rd_pend;
        pop      = valid_w && m.m_ready;
        occ_next = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};
        issue    = (state == RUN) && (rd_cnt < num_q) && (occ_next < 3'd2);
        last_w   = valid_w && (out_cnt == num_q - ONE);

        MEM_CEB  = !issue;
        MEM_WEN  = 1'b1;
        MEM_ADDR = issue ? (base_q + rd_cnt[ADDR_W-1:0]) : '0;

        m.m_valid = valid_w;
        m.m_last  = last_w;
        if (fifo_cnt != 2'd0)
            m.m_data = slot0;
        else if (rd_pend)
            m.m_data = MEM_DOUT;
        else
            m.m_data = '0;

        busy = (state == RUN);
        done = (state == DONE);
    end

    // Next-state logic for the run sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_words == '0) ? DONE : RUN;
            RUN:  if (pop && last_w) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, run counters and the skid buffer. When a word returns
    // while the buffer is empty and is accepted at once, nothing is stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            rd_pend  <= 1'b0;
            fifo_cnt <= 2'd0;
            slot0    <= '0;
            slot1    <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= issue;

            if (state == IDLE && start) begin
                base_q  <= base_addr;
                num_q   <= num_words;
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (issue) rd_cnt  <= rd_cnt + ONE;
                if (pop)   out_cnt <= out_cnt + ONE;
            end

            if (rd_pend && !pop) begin
                if (fifo_cnt == 2'd0) slot0 <= MEM_DOUT;
                else                  slot1 <= MEM_DOUT;
                fifo_cnt <= fifo_cnt + 2'd1;
            end else if (!rd_pend && pop) begin
                slot0    <= slot1;
                fifo_cnt <= fifo_cnt - 2'd1;
            end else if (rd_pend && pop) begin
                if (fifo_cnt == 2'd1) begin
                    slot0 <= MEM_DOUT;
                end else if (fifo_cnt == 2'd2) begin
                    slot0 <= slot1;
                    slot1 <= MEM_DOUT;
                end
            end
        end
    end

    // The credit rule must keep a returning word from ever finding both
    // slots occupied with nothing leaving.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(rd_pend && !pop && fifo_cnt == 2'd2));

endmodule
